// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter sharing one combinational 4-bit ALU
// among NUM_REQ requesters, returning result + requester ID on a
// valid/ready response channel.
// Optional build macro ALU_ARB_PRIO_EN: requester 0 gets strict priority and
// round-robin runs over requesters 1..NUM_REQ-1 only.
module alu_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0] req_op,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_sel,
    input  logic [7:0]           alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    localparam int unsigned OPND_W = 4;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned RES_W  = 8;

`ifdef ALU_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OPND_W-1:0]   a_q, a_d;
    logic [OPND_W-1:0]   b_q, b_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;

    logic                grant_any;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     scan_idx;
    int unsigned         win_i;

    // Winner search: descending scan so the valid index closest to rr_ptr is the last one assigned.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
            if (req_valid[scan_idx] && !(PRIO_EN && (scan_idx == '0))) begin
                grant_any = 1'b1;
                winner    = scan_idx;
            end
        end
        if (PRIO_EN && req_valid[0]) begin
            grant_any = 1'b1;
            winner    = '0;
        end
        win_i = 32'(winner);
    end

    // Grant strobe: only in IDLE, and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && grant_any && rst_n) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next-state and datapath capture.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    a_d     = req_a[win_i*OPND_W +: OPND_W];
                    b_d     = req_b[win_i*OPND_W +: OPND_W];
                    op_d    = req_op[win_i*OP_W +: OP_W];
                    id_d    = winner;
                    state_d = EXEC;
                    // A priority grant to requester 0 leaves the rotation untouched.
                    if (!(PRIO_EN && (winner == '0))) begin
                        rr_ptr_d = ID_W'((win_i + 1) % NUM_REQ);
                    end
                end
            end
            EXEC: begin
                rsp_data_d  = alu_result;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized traffic including random resets.
module tb_alu_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

`ifdef ALU_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [3*NUM_REQ-1:0] req_op;
    logic [3:0]           alu_a;
    logic [3:0]           alu_b;
    logic [2:0]           alu_sel;
    logic [7:0]           alu_result;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    // Shared ALU stand-in
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0: return 8'(a) + 8'(b);
            3'd1: return 8'(a) - 8'(b);
            3'd2: return {4'h0, a & b};
            3'd3: return {4'h0, a | b};
            3'd4: return {4'h0, a ^ b};
            3'd5: return {~b, ~a};
            3'd6: return 8'(a) * 8'(b);
            default: return (b == 4'd0) ? 8'h00 : 8'(a) / 8'(b);
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

    // Reference model: one outstanding transaction, response pending flag, pointer
    bit         m_known = 1'b0;
    bit         m_outstanding;
    bit         m_responding;
    int         m_ptr;
    logic [3:0] m_a, m_b;
    logic [2:0] m_op;
    int         m_id;
    logic [7:0] m_rsp_data;
    int         m_rsp_id;

    function automatic int pick();
        if (PRIO && req_valid[0]) return 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (!(PRIO && i == 0) && req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare outputs against the model, advance the model, and step one clock.
    task automatic cycle();
        int w;
        logic [NUM_REQ-1:0] exp_rdy;
        #1;
        w = (m_known && !m_outstanding && rst_n) ? pick() : -1;
        if (m_known) begin
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy",      32'(busy),      32'(m_outstanding));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_responding));
            chk("rsp_data",  32'(rsp_data),  32'(m_rsp_data));
            chk("rsp_id",    32'(rsp_id),    32'(m_rsp_id));
            chk("alu_a",     32'(alu_a),     32'(m_a));
            chk("alu_b",     32'(alu_b),     32'(m_b));
            chk("alu_sel",   32'(alu_sel),   32'(m_op));
        end
        if (!rst_n) begin
            m_known = 1'b1; m_outstanding = 1'b0; m_responding = 1'b0; m_ptr = 0;
            m_a = '0; m_b = '0; m_op = '0; m_id = 0; m_rsp_data = '0; m_rsp_id = 0;
        end else if (m_known) begin
            if (!m_outstanding) begin
                if (w >= 0) begin
                    m_a  = req_a[4*w +: 4];
                    m_b  = req_b[4*w +: 4];
                    m_op = req_op[3*w +: 3];
                    m_id = w;
                    m_outstanding = 1'b1;
                    if (!(PRIO && w == 0)) m_ptr = (w + 1) % NUM_REQ;
                end
            end else if (!m_responding) begin
                m_rsp_data   = alu_fn(m_a, m_b, m_op);
                m_rsp_id     = m_id;
                m_responding = 1'b1;
            end else if (rsp_ready) begin
                m_responding  = 1'b0;
                m_outstanding = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_req(input int i, input int a, input int b, input int op);
        req_a[4*i +: 4]  = 4'(a);
        req_b[4*i +: 4]  = 4'(b);
        req_op[3*i +: 3] = 3'(op);
    endtask

    // Run n cycles, collecting grant indices/cycles and response data.
    int gq[$];
    int gc[$];
    int dq[$];
    task automatic collect(input int n);
        gq.delete(); gc.delete(); dq.delete();
        repeat (n) begin
            #1;
            if (req_ready != '0) begin
                gq.push_back(onehot_idx(req_ready));
                gc.push_back(cyc);
            end
            if (rsp_valid) dq.push_back(int'(rsp_data));
            cycle();
        end
    endtask

    int exp_g3[5];
    int exp_d3[5];
    int exp_g5[3];

    initial begin
        if (PRIO) begin
            exp_g3 = '{0, 0, 0, 0, 0};
            exp_d3 = '{1, 1, 1, 1, 1};
            exp_g5 = '{0, 0, 0};
        end else begin
            exp_g3 = '{0, 1, 2, 3, 0};
            exp_d3 = '{1, 2, 3, 4, 1};
            exp_g5 = '{3, 0, 3};
        end

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_rsp_data",  32'(rsp_data),  32'd0);
        chk("reset_alu",       32'({alu_a, alu_b, alu_sel}), 32'd0);

        // Single request: 9*3 on requester 2
        set_req(2, 9, 3, 6); req_valid = 4'b0100; rsp_ready = 1'b1;
        #1 chk("t2_grant", 32'(req_ready), 32'b0100);
        cycle();
        #1 chk("t2_no_regrant", 32'(req_ready), 32'd0);
        cycle();
        req_valid = '0;
        #1;
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_data",  32'(rsp_data),  32'h1B);
        chk("t2_rsp_id",    32'(rsp_id),    32'd2);
        cycle();
        #1 chk("t2_idle", 32'(busy), 32'd0);

        // Fairness with all requesters valid
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i, 1, 0);
        req_valid = 4'hF; rsp_ready = 1'b1;
        collect(15);
        chk("t3_ngrants", 32'(gq.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk("t3_grant", 32'((k < gq.size()) ? gq[k] : -1), 32'(exp_g3[k]));
            chk("t3_data",  32'((k < dq.size()) ? dq[k] : -1), 32'(exp_d3[k]));
        end
        for (int k = 0; k + 1 < gc.size(); k++) chk("t3_spacing", 32'(gc[k+1] - gc[k]), 32'd3);

        // Backpressure on a divide-by-zero response
        set_req(1, 7, 0, 7); req_valid = 4'b0010; rsp_ready = 1'b0;
        #1 chk("t4_grant", 32'(req_ready), 32'b0010);
        cycle();
        req_valid = 4'hF;
        cycle();
        repeat (5) begin
            #1;
            chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_data",  32'(rsp_data),  32'h00);
            chk("t4_no_grant",   32'(req_ready), 32'd0);
            cycle();
        end
        rsp_ready = 1'b1;
        cycle();
        req_valid = '0;
        #1;
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_rsp_done", 32'(rsp_valid), 32'd0);

        // Withdraw during busy, then wrap from pointer 3
        set_req(2, 1, 1, 2); req_valid = 4'b0100; rsp_ready = 1'b1;
        cycle();
        req_valid = 4'b0001; cycle();
        req_valid = 4'b1000; cycle();
        req_valid = 4'b1001;
        collect(9);
        chk("t5_ngrants", 32'(gq.size()), 32'd3);
        for (int k = 0; k < 3; k++) chk("t5_grant", 32'((k < gq.size()) ? gq[k] : -1), 32'(exp_g5[k]));
        req_valid = '0;

        // Reset in the middle of a held response
        set_req(2, 5, 5, 4); req_valid = 4'b0100; rsp_ready = 1'b0;
        cycle();
        req_valid = '0; cycle();
        cycle();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t1_busy",      32'(busy),      32'd0);
        req_valid = 4'b1010;
        #1 chk("t1_lowest", 32'(req_ready), 32'b0010);
        cycle();
        req_valid = '0; rsp_ready = 1'b1;
        repeat (3) cycle();

`ifdef ALU_ARB_PRIO_EN
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        req_valid = 4'hF;
        collect(12);
        for (int k = 0; k < 4; k++) chk("t6_prio", 32'((k < gq.size()) ? gq[k] : -1), 32'd0);
        req_valid = 4'b1110;
        collect(12);
        for (int k = 0; k < 4; k++) chk("t6_rot", 32'((k < gq.size()) ? gq[k] : -1), 32'((k % 3) + 1));
`endif

        // Randomized traffic
        repeat (3000) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            req_valid = NUM_REQ'($urandom);
            req_a     = (4*NUM_REQ)'($urandom);
            req_b     = (4*NUM_REQ)'($urandom);
            req_op    = (3*NUM_REQ)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares a single combinational 4-bit ALU (8-bit result, 3-bit op select) among NUM_REQ requesters.
- Arbitrates round-robin, latches the winner's operands, drives the ALU and captures its result.
- Returns the result with the requester ID over a valid/ready response channel.
- Sits between the ui_in/uio_in input-decode logic of the top-level wrapper and the shared ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  4*NUM_REQ  operand A; requester i uses bits [4i+3:4i].
- req_b  input  4*NUM_REQ  operand B, packed the same way.
- req_op  input  3*NUM_REQ  op select; requester i uses bits [3i+2:3i].
- alu_a  output  4  operand A to the shared ALU.
- alu_b  output  4  operand B to the shared ALU.
- alu_sel  output  3  op select to the shared ALU.
- alu_result  input  8  combinational ALU result.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  8  captured ALU result.
- rsp_id  output  ID_W  index of the requester that owns the response.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, latched a/b/op/id=0, rsp_data=0, rsp_id=0, rsp_valid=0, req_ready=0, busy=0, alu_a/alu_b/alu_sel=0.
- A reset during EXEC or RESP discards the transaction; no response is produced.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick the winner: the first set bit scanning upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
  - req_ready[winner] is driven combinationally high in this cycle only.
  - On the clock edge: latch the winner's a/b/op and ID, set rr_ptr = (winner+1) mod NUM_REQ, go to EXEC.
  - If no req_valid is high: stay in IDLE, req_ready=0, rr_ptr unchanged.
- EXEC:
  - alu_a/alu_b/alu_sel are driven from the latched registers. They hold those values in every state and change only on a grant.
  - On the edge: rsp_data <= alu_result, rsp_id <= latched ID, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - If rsp_ready is high: on the edge rsp_valid <= 0 and go to IDLE. Otherwise stay in RESP.
- No new grant is made while in EXEC or RESP; req_ready=0 there.
- Latency: grant at edge N, then rsp_valid is high after edge N+2. Minimum spacing between grants is 3 cycles (with rsp_ready held high).
- Requester rule: a requester keeps req_valid and its operands stable until it sees req_ready. The arbiter does not check this.
- Deasserting req_valid before a grant withdraws the request without side effects.
- Operand and result encoding is fixed by the ALU:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 {~b,~a}, 110 mul, 111 div.
  - Divide by zero yields 0x00.
  - Results are passed through unmodified, full 8 bits.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0,...

Optional Feature:
- Macro: ALU_ARB_PRIO_EN.
- Defined:
  - Requester 0 has strict priority. Whenever req_valid[0] is high in IDLE it wins, regardless of rr_ptr.
  - A requester-0 grant does not update rr_ptr.
  - Round-robin applies among requesters 1..NUM_REQ-1 when req_valid[0] is low; the scan starts at rr_ptr and skips index 0.
- Undefined: pure round-robin over all requesters, as described in Behaviour.

Test Plan:
1. Reset mid-RESP (rsp_ready=0) -> the next cycle after rst_n=0 shows rsp_valid=0, busy=0, rr_ptr=0; the following grant goes to the lowest valid index.
2. Single request, NUM_REQ=4:
   - Stimulus: req_valid=0100, requester 2 a=9, b=3, op=110, rsp_ready=1.
   - Response: req_ready=0100 for exactly one cycle; 2 edges later rsp_valid=1, rsp_data=0x1B, rsp_id=2.
3. All four valid continuously, rsp_ready=1, op=000 with a=i, b=1 -> grants occur in order 0,1,2,3,0; rsp_data equals 1,2,3,4,1; grants are 3 cycles apart.
4. Backpressure: rsp_ready=0 for 5 cycles during RESP (op=111, a=7, b=0) -> rsp_data=0x00 held stable, req_ready=0 throughout; IDLE is reached one cycle after rsp_ready=1.
5. Withdraw and wrap:
   - Stimulus: rr_ptr=3 after a grant to 2; req_valid=0001 and 1000 alternate.
   - Response: requester 3 is granted before 0; the pointer wraps correctly.
6. With ALU_ARB_PRIO_EN defined: req_valid=1111 continuously -> requester 0 wins every grant; with req_valid=1110, grants rotate 1,2,3,1.
